// File: rtl/ysyx_041514_trap_seq.sv
// ysyx_041514_trap_seq
// Sequences the pipeline through one trap, mret or fence.i event. An event is
// accepted in IDLE, the sequencer optionally waits in DRAIN for the data bus to
// go quiet, then pulses the CSR commit strobe and the fetch redirect strobe.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no event in flight; accepts the highest-priority request
// DRAIN    | waiting for mem_busy_i to drop (or for the watchdog)
// COMMIT   | one cycle: commit_o/flush_o high, CSRs written
// REDIRECT | one cycle: redirect_valid_o high, fetch restarts
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inst_valid_i              mem stage holds a valid instruction
//   exc_valid_i, exc_code_i   synchronous exception and its code
//   mret_i, fencei_i          mem-stage instruction is mret / fence.i
//   mstatus_mie_i             global interrupt enable
//   irq_mei_i/msi_i/mti_i     pending-and-enabled machine interrupts
//   mem_busy_i                data-bus transaction outstanding
//   stall_o, flush_o          pipeline hold / kill IF..MEM
//   commit_o                  one-cycle CSR write strobe
//   kind_o, cause_o           latched event kind (0 trap,1 mret,2 fencei) and mcause
//   redirect_valid_o          one-cycle fetch redirect strobe
//   drain_cycles_o            cycles spent in DRAIN by the last event (saturating)
//   drain_timeout_o           sticky drain watchdog flag
module ysyx_041514_trap_seq #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_code_i,
  input  logic            mret_i,
  input  logic            fencei_i,
  input  logic            mstatus_mie_i,
  input  logic            irq_mei_i,
  input  logic            irq_msi_i,
  input  logic            irq_mti_i,
  input  logic            mem_busy_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            commit_o,
  output logic [1:0]      kind_o,
  output logic [XLEN-1:0] cause_o,
  output logic            redirect_valid_o,
  output logic [7:0]      drain_cycles_o,
  output logic            drain_timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [1:0] KIND_TRAP   = 2'd0;
  localparam logic [1:0] KIND_MRET   = 2'd1;
  localparam logic [1:0] KIND_FENCEI = 2'd2;

  localparam logic [XLEN-1:0] INT_BIT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] CAUSE_MEI = INT_BIT | XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MSI = INT_BIT | XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_MTI = INT_BIT | XLEN'(7);

  localparam logic [7:0] DRAIN_LIM = 8'(DRAIN_MAX);

  state_t          state;
  logic            commit_q;
  logic            redirect_q;

  logic            irq_ok;
  logic            req_any;
  logic            accept;
  logic [1:0]      next_kind;
  logic [XLEN-1:0] next_cause;
  logic [7:0]      drain_inc;

  // Interrupts need a valid instruction in mem so mepc has a return address.
  assign irq_ok  = mstatus_mie_i & inst_valid_i;
  assign req_any = (irq_ok & (irq_mei_i | irq_msi_i | irq_mti_i))
                 | exc_valid_i | mret_i | fencei_i;
  assign accept  = ~rst & (state == IDLE) & req_any;

  // Priority: MEI > MSI > MTI > exception > mret > fencei.
  always_comb begin
    next_kind  = KIND_TRAP;
    next_cause = '0;
    if (irq_ok && irq_mei_i) begin
      next_cause = CAUSE_MEI;
    end else if (irq_ok && irq_msi_i) begin
      next_cause = CAUSE_MSI;
    end else if (irq_ok && irq_mti_i) begin
      next_cause = CAUSE_MTI;
    end else if (exc_valid_i) begin
      next_cause = {{(XLEN-4){1'b0}}, exc_code_i};
    end else if (mret_i) begin
      next_kind = KIND_MRET;
    end else if (fencei_i) begin
      next_kind = KIND_FENCEI;
    end
  end

  assign drain_inc = (drain_cycles_o == 8'hFF) ? 8'hFF : drain_cycles_o + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      kind_o          <= KIND_TRAP;
      cause_o         <= '0;
      drain_cycles_o  <= 8'd0;
      drain_timeout_o <= 1'b0;
      commit_q        <= 1'b0;
      redirect_q      <= 1'b0;
    end else begin
      commit_q   <= 1'b0;
      redirect_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            kind_o         <= next_kind;
            cause_o        <= next_cause;
            drain_cycles_o <= 8'd0;
            if (mem_busy_i) begin
              state <= DRAIN;
            end else begin
              state    <= COMMIT;
              commit_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          drain_cycles_o <= drain_inc;
          if (!mem_busy_i) begin
            state    <= COMMIT;
            commit_q <= 1'b1;
          end else if (drain_inc >= DRAIN_LIM) begin
            // Watchdog: give up waiting and commit anyway, flagging it.
            state           <= COMMIT;
            commit_q        <= 1'b1;
            drain_timeout_o <= 1'b1;
          end
        end
        COMMIT: begin
          state      <= REDIRECT;
          redirect_q <= 1'b1;
        end
        REDIRECT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are masked by rst so nothing leaks out during a reset cycle.
  assign stall_o          = ~rst & ((state != IDLE) | accept);
  assign commit_o         = ~rst & commit_q;
  assign flush_o          = ~rst & commit_q;
  assign redirect_valid_o = ~rst & redirect_q;

endmodule

// File: tb/tb_ysyx_041514_trap_seq.sv
// Bench for ysyx_041514_trap_seq: directed scenarios plus random traffic, all
// checked every cycle against a cycle-numbered reference model.
module tb_ysyx_041514_trap_seq;

  localparam int DMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, exc_valid_i, mret_i, fencei_i, mstatus_mie_i;
  logic [3:0]  exc_code_i;
  logic        irq_mei_i, irq_msi_i, irq_mti_i, mem_busy_i;
  logic        stall_o, flush_o, commit_o, redirect_valid_o, drain_timeout_o;
  logic [1:0]  kind_o;
  logic [63:0] cause_o;
  logic [7:0]  drain_cycles_o;

  ysyx_041514_trap_seq #(.XLEN(64), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
    .mret_i(mret_i), .fencei_i(fencei_i), .mstatus_mie_i(mstatus_mie_i),
    .irq_mei_i(irq_mei_i), .irq_msi_i(irq_msi_i), .irq_mti_i(irq_mti_i),
    .mem_busy_i(mem_busy_i),
    .stall_o(stall_o), .flush_o(flush_o), .commit_o(commit_o),
    .kind_o(kind_o), .cause_o(cause_o), .redirect_valid_o(redirect_valid_o),
    .drain_cycles_o(drain_cycles_o), .drain_timeout_o(drain_timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;
  int n_commits, n_redirs;

  // reference model: an event is a window of cycle numbers
  bit          m_active = 0;
  bit          m_drain  = 0;
  int          m_commit_at = -10;
  int          m_dcnt = 0;
  bit          m_to   = 0;
  int          m_kind = 0;
  logic [63:0] m_cause = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic idle_in();
    rst = 0; inst_valid_i = 1; exc_valid_i = 0; exc_code_i = 0; mret_i = 0;
    fencei_i = 0; mstatus_mie_i = 1; irq_mei_i = 0; irq_msi_i = 0; irq_mti_i = 0;
    mem_busy_i = 0;
  endtask

  // Checks the current cycle against the model, then advances one clock.
  task automatic cyc();
    bit          irq, acc;
    int          k;
    logic [63:0] c;
    #1;
    irq = mstatus_mie_i && inst_valid_i;
    acc = !rst && !m_active && ((irq && (irq_mei_i || irq_msi_i || irq_mti_i))
          || exc_valid_i || mret_i || fencei_i);
    chk("stall",    stall_o,          !rst && (m_active || acc));
    chk("commit",   commit_o,         !rst && m_active && (t == m_commit_at));
    chk("flush",    flush_o,          !rst && m_active && (t == m_commit_at));
    chk("redirect", redirect_valid_o, !rst && m_active && (t == m_commit_at + 1));
    chk("kind",     kind_o,           m_kind);
    chk("cause",    cause_o,          m_cause);
    chk("dcycles",  drain_cycles_o,   m_dcnt);
    chk("timeout",  drain_timeout_o,  m_to);
    if (commit_o) n_commits++;
    if (redirect_valid_o) n_redirs++;
    k = 0; c = '0;
    if (irq && irq_mei_i)      c = 64'h8000_0000_0000_000B;
    else if (irq && irq_msi_i) c = 64'h8000_0000_0000_0003;
    else if (irq && irq_mti_i) c = 64'h8000_0000_0000_0007;
    else if (exc_valid_i)      c = 64'(exc_code_i);
    else if (mret_i)           k = 1;
    else                       k = 2;
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_drain = 0; m_dcnt = 0; m_to = 0; m_kind = 0; m_cause = '0;
      m_commit_at = -10;
    end else if (acc) begin
      m_active = 1; m_kind = k; m_cause = c; m_dcnt = 0;
      if (mem_busy_i) begin m_drain = 1; m_commit_at = -10; end
      else m_commit_at = t + 1;
    end else if (m_active) begin
      if (m_drain) begin
        m_dcnt = (m_dcnt < 255) ? m_dcnt + 1 : 255;
        if (!mem_busy_i) begin
          m_drain = 0; m_commit_at = t + 1;
        end else if (m_dcnt >= DMAX) begin
          m_drain = 0; m_commit_at = t + 1; m_to = 1;
        end
      end else if (t == m_commit_at + 1) begin
        m_active = 0;
      end
    end
    t++;
    #1;
  endtask

  task automatic run_idle(input int n);
    idle_in();
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    idle_in();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("reset_stall", stall_o, 0);
    chk("reset_cause", cause_o, 0);
    run_idle(7);

    // MTI, no drain
    idle_in(); irq_mti_i = 1; n_commits = 0;
    cyc();
    idle_in();
    chk("mti_commit", commit_o, 1);
    chk("mti_flush",  flush_o, 1);
    chk("mti_cause",  cause_o, 64'h8000_0000_0000_0007);
    chk("mti_kind",   kind_o, 0);
    cyc();
    chk("mti_redir",  redirect_valid_o, 1);
    cyc();
    chk("mti_idle",   stall_o, 0);
    run_idle(3);

    // simultaneous MEI + exception + mret
    idle_in(); irq_mei_i = 1; exc_valid_i = 1; exc_code_i = 4'd2; mret_i = 1;
    n_commits = 0;
    cyc(); cyc(); cyc();
    idle_in();
    chk("simul_cause", cause_o, 64'h8000_0000_0000_000B);
    chk("simul_kind",  kind_o, 0);
    run_idle(3);
    chk("simul_ncommit", n_commits, 1);

    // drain of 4 cycles
    idle_in(); exc_valid_i = 1; exc_code_i = 4'd5; mem_busy_i = 1;
    cyc();
    idle_in(); mem_busy_i = 1;
    cyc(); cyc(); cyc();
    mem_busy_i = 0;
    cyc();
    chk("drain_commit",  commit_o, 1);
    chk("drain_cycles",  drain_cycles_o, 4);
    chk("drain_cause",   cause_o, 5);
    chk("drain_timeout", drain_timeout_o, 0);
    run_idle(3);

    // watchdog
    idle_in(); exc_valid_i = 1; exc_code_i = 4'd7; mem_busy_i = 1;
    cyc();
    idle_in(); mem_busy_i = 1;
    for (int i = 0; i < DMAX; i++) cyc();
    chk("wd_commit",  commit_o, 1);
    chk("wd_timeout", drain_timeout_o, 1);
    chk("wd_cycles",  drain_cycles_o, DMAX);
    run_idle(3);
    idle_in(); mret_i = 1;
    cyc();
    run_idle(3);
    chk("wd_sticky",  drain_timeout_o, 1);
    chk("mret_kind",  kind_o, 1);

    // gating
    idle_in(); irq_mti_i = 1; inst_valid_i = 0; n_commits = 0;
    cyc(); cyc();
    idle_in(); irq_mti_i = 1; mstatus_mie_i = 0;
    cyc(); cyc();
    run_idle(2);
    chk("gate_ncommit", n_commits, 0);
    idle_in(); irq_mti_i = 1; inst_valid_i = 0; fencei_i = 1;
    cyc();
    idle_in();
    chk("gate_kind",  kind_o, 2);
    chk("gate_cause", cause_o, 0);
    run_idle(3);

    // reset mid-DRAIN
    idle_in(); exc_valid_i = 1; exc_code_i = 4'd9; mem_busy_i = 1;
    cyc();
    idle_in(); mem_busy_i = 1;
    cyc(); cyc();
    rst = 1;
    cyc();
    idle_in();
    chk("rst_stall",   stall_o, 0);
    chk("rst_kind",    kind_o, 0);
    chk("rst_cause",   cause_o, 0);
    chk("rst_cycles",  drain_cycles_o, 0);
    chk("rst_timeout", drain_timeout_o, 0);
    n_commits = 0; n_redirs = 0;
    run_idle(6);
    chk("rst_ncommit", n_commits, 0);
    chk("rst_nredir",  n_redirs, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(99) == 0);
      inst_valid_i  = ($urandom_range(3) != 0);
      mstatus_mie_i = ($urandom_range(3) != 0);
      irq_mei_i     = ($urandom_range(15) == 0);
      irq_msi_i     = ($urandom_range(15) == 0);
      irq_mti_i     = ($urandom_range(15) == 0);
      exc_valid_i   = ($urandom_range(7) == 0);
      exc_code_i    = 4'($urandom);
      mret_i        = ($urandom_range(9) == 0);
      fencei_i      = ($urandom_range(9) == 0);
      mem_busy_i    = ($urandom_range(9) < 6);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_041514_trap_seq.md
YSYX_041514_TRAP_SEQ -- requirements
Module: ysyx_041514_trap_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled on the rising edge of clk.
REQ-002 Parameter XLEN SHALL default to 64 and sets the width of the cause datapath.
REQ-003 Parameter DRAIN_MAX SHALL default to 255 and sets the drain watchdog limit in cycles (legal range 1..255).
REQ-004 The block SHALL have exactly these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- inst_valid_i  in  1  mem stage holds a valid instruction
- exc_valid_i  in  1  synchronous exception raised by the mem-stage instruction
- exc_code_i  in  4  exception code (0..15)
- mret_i  in  1  mem-stage instruction is mret
- fencei_i  in  1  mem-stage instruction is fence.i
- mstatus_mie_i  in  1  global interrupt enable
- irq_mei_i / irq_msi_i / irq_mti_i  in  1 each  pending-and-enabled machine external / software / timer interrupt
- mem_busy_i  in  1  a data-bus transaction is outstanding
- stall_o  out  1  hold all pipeline stages
- flush_o  out  1  kill IF..MEM stage contents
- commit_o  out  1  one-cycle CSR write strobe (mepc/mcause/mtval/mstatus)
- kind_o  out  2  latched event: 0 = trap, 1 = mret, 2 = fencei
- cause_o  out  XLEN  latched mcause value
- redirect_valid_o  out  1  one-cycle fetch-redirect strobe
- drain_cycles_o  out  8  cycles spent in DRAIN by the last event (saturating)
- drain_timeout_o  out  1  sticky watchdog flag

Function
REQ-005 The FSM SHALL have four states, IDLE, DRAIN, COMMIT and REDIRECT, encoded in 2 bits.
REQ-006 In IDLE an event SHALL be accepted when any of these is true:
- irq_any && mstatus_mie_i && inst_valid_i, where irq_any = mei|msi|mti
- exc_valid_i
- mret_i
- fencei_i
REQ-007 Arbitration priority SHALL be MEI > MSI > MTI > exception > mret > fencei.
REQ-008 Exactly one event SHALL be latched per acceptance; all lower-priority requests in that cycle are dropped.
REQ-009 Latched cause_o SHALL be:
- MEI: {1, 63'd11}
- MSI: {1, 63'd3}
- MTI: {1, 63'd7}
- exception: {1'b0, 59'b0, exc_code_i}
- mret/fencei: 0
REQ-010 kind_o SHALL be 0 for interrupts and exceptions, 1 for mret, and 2 for fencei.
REQ-011 On acceptance with mem_busy_i=0 the FSM SHALL go IDLE -> COMMIT; with mem_busy_i=1 it SHALL go IDLE -> DRAIN.
REQ-012 On acceptance, drain_cycles_o SHALL be cleared to 0.
REQ-013 In DRAIN, drain_cycles_o SHALL increment by 1 per cycle and saturate at 255.
REQ-014 DRAIN SHALL go to COMMIT in the first cycle mem_busy_i=0 is sampled.
REQ-015 DRAIN SHALL also go to COMMIT when the counter reaches DRAIN_MAX, and in that case SHALL set drain_timeout_o.
REQ-016 COMMIT SHALL last exactly 1 cycle with commit_o=1 and flush_o=1, then go to REDIRECT.
REQ-017 REDIRECT SHALL last exactly 1 cycle with redirect_valid_o=1, then go to IDLE.
REQ-018 stall_o SHALL be 1 in the acceptance cycle and in every cycle in DRAIN, COMMIT and REDIRECT.
REQ-019 stall_o SHALL be 0 in IDLE when no event is accepted.
REQ-020 The acceptance-cycle stall SHALL be combinational.
REQ-021 Minimum latency SHALL be: accept at cycle N, commit_o at N+1, redirect_valid_o at N+2, next acceptance possible at N+3.
REQ-022 Requests presented outside IDLE SHALL be ignored; upstream holds them under stall_o.
REQ-023 An interrupt that deasserts after acceptance SHALL still complete its sequence with the latched cause.
REQ-024 kind_o and cause_o SHALL be registered and stable from the cycle after acceptance through REDIRECT.
REQ-025 kind_o and cause_o SHALL retain their last value in IDLE.
REQ-026 Interrupts SHALL NOT be accepted while inst_valid_i=0, so that mepc always has a valid return address; exceptions, mret and fencei do not require inst_valid_i.
REQ-027 drain_timeout_o SHALL stay 1 until rst; subsequent events do not clear it.

Reset
REQ-028 When rst=1 at a clock edge, the following SHALL be forced on that edge regardless of FSM state, including mid-DRAIN or mid-COMMIT:
- state = IDLE
- kind_o = 0, cause_o = 0
- drain_cycles_o = 0, drain_timeout_o = 0
REQ-029 While rst=1, stall_o, flush_o, commit_o and redirect_valid_o SHALL be 0.
REQ-030 A sequence interrupted by reset SHALL NOT produce commit_o or redirect_valid_o after reset deasserts.

Verification
REQ-031 Bench scenario, MTI with no drain: mstatus_mie_i=1, inst_valid_i=1, irq_mti_i=1, mem_busy_i=0 at cycle 10 -> stall_o=1 at 10, commit_o=1 and flush_o=1 at 11, cause_o=0x8000000000000007, kind_o=0, redirect_valid_o=1 at 12, IDLE at 13.
REQ-032 Bench scenario, simultaneous requests: irq_mei_i=1, exc_valid_i=1 (code 2) and mret_i=1 in one cycle -> cause_o=0x800000000000000B, kind_o=0, exactly one commit_o pulse.
REQ-033 Bench scenario, drain: exc_valid_i=1, exc_code_i=5, mem_busy_i=1 for 4 cycles after acceptance -> commit_o 5 cycles after acceptance, drain_cycles_o=4, cause_o=5, drain_timeout_o=0.
REQ-034 Bench scenario, watchdog: DRAIN_MAX=8, mem_busy_i held 1 -> COMMIT after 8 DRAIN cycles, drain_timeout_o=1 and sticky across a following mret.
REQ-035 Bench scenario, gating: irq_mti_i=1 with inst_valid_i=0, or with mstatus_mie_i=0, -> no stall_o and no commit_o; fencei_i=1 in the same cycle -> kind_o=2, cause_o=0.
REQ-036 Bench scenario, reset mid-DRAIN: rst=1 for 1 cycle while in DRAIN -> all outputs 0 on the next cycle, and no commit_o or redirect_valid_o pulse after rst deasserts.
